// File: rtl/bitslip_align_ctrl.sv
// Bitslip alignment sequencer: walks each deserialiser lane, slipping until the training word is seen.
// Latency: per lane SETTLE cycles before every compare run; all outputs registered (one cycle after state decision).
// Backpressure: none; start is only accepted in IDLE/DONE and ignored while busy.
module bitslip_align_ctrl #(
  parameter int         LANES     = 4,
  parameter logic [9:0] PATTERN   = 10'h01F,
  parameter int         SETTLE    = 16,
  parameter int         LOCK_CNT  = 8,
  parameter int         MAX_SLIPS = 20
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [LANES*10-1:0]   data,
  output logic [LANES-1:0]      bitslip,
  output logic                  busy,
  output logic                  done,
  output logic [LANES-1:0]      lane_locked,
  output logic [LANES-1:0]      lane_fail
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0]    LOCK_LIM    = 8'(LOCK_CNT);
  localparam logic [7:0]    SLIP_LIM    = 8'(MAX_SLIPS);
  localparam logic [LW-1:0] LAST_LANE   = LW'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_NEXT, S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [LW-1:0]    r_lane, w_lane_nxt;
  logic [7:0]       r_settle_cnt, w_settle_nxt;
  logic [7:0]       r_slip_cnt, w_slip_nxt;
  logic [7:0]       r_match_cnt, w_match_nxt;
  logic [LANES-1:0] r_locked, w_locked_nxt;
  logic [LANES-1:0] r_fail, w_fail_nxt;
  logic [LANES-1:0] r_bitslip, w_bitslip_nxt;
  logic             r_busy, r_done;
  logic [9:0]       w_word;
  logic [7:0]       w_match_inc;
  logic [7:0]       w_slip_inc;

  // Only the lane currently being aligned is looked at; counters saturate rather than wrap.
  always_comb begin
    w_word      = data[10*r_lane +: 10];
    w_match_inc = (r_match_cnt == 8'hFF) ? 8'hFF : r_match_cnt + 8'd1;
    w_slip_inc  = (r_slip_cnt == 8'hFF) ? 8'hFF : r_slip_cnt + 8'd1;
  end

  // Next-state and counter/flag updates; bitslip pulse is decoded from the next state so it is registered.
  always_comb begin
    w_state_nxt  = r_state;
    w_lane_nxt   = r_lane;
    w_settle_nxt = r_settle_cnt;
    w_slip_nxt   = r_slip_cnt;
    w_match_nxt  = r_match_cnt;
    w_locked_nxt = r_locked;
    w_fail_nxt   = r_fail;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt  = S_SETTLE;
          w_lane_nxt   = '0;
          w_settle_nxt = '0;
          w_slip_nxt   = '0;
          w_match_nxt  = '0;
          w_locked_nxt = '0;
          w_fail_nxt   = '0;
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt >= SETTLE_LAST) begin
          w_state_nxt  = S_CHECK;
          w_settle_nxt = '0;
        end else begin
          w_settle_nxt = r_settle_cnt + 8'd1;
        end
      end
      S_CHECK: begin
        if (w_word == PATTERN) begin
          w_match_nxt = w_match_inc;
          if (w_match_inc >= LOCK_LIM) begin
            w_locked_nxt[r_lane] = 1'b1;
            w_state_nxt          = S_NEXT;
          end
        end else begin
          w_match_nxt = '0;
          if (r_slip_cnt >= SLIP_LIM) begin
            w_fail_nxt[r_lane] = 1'b1;
            w_state_nxt        = S_NEXT;
          end else begin
            w_state_nxt = S_SLIP;
          end
        end
      end
      S_SLIP: begin
        w_slip_nxt   = w_slip_inc;
        w_settle_nxt = '0;
        w_state_nxt  = S_SETTLE;
      end
      S_NEXT: begin
        if (r_lane == LAST_LANE) begin
          w_state_nxt = S_DONE;
        end else begin
          w_lane_nxt   = r_lane + 1'b1;
          w_slip_nxt   = '0;
          w_match_nxt  = '0;
          w_settle_nxt = '0;
          w_state_nxt  = S_SETTLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_bitslip_nxt = '0;
    if (w_state_nxt == S_SLIP) w_bitslip_nxt[w_lane_nxt] = 1'b1;
  end

  // State, counters and registered outputs; reset cuts any in-flight slip pulse immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_lane       <= '0;
      r_settle_cnt <= '0;
      r_slip_cnt   <= '0;
      r_match_cnt  <= '0;
      r_locked     <= '0;
      r_fail       <= '0;
      r_bitslip    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lane       <= w_lane_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_slip_cnt   <= w_slip_nxt;
      r_match_cnt  <= w_match_nxt;
      r_locked     <= w_locked_nxt;
      r_fail       <= w_fail_nxt;
      r_bitslip    <= w_bitslip_nxt;
      r_busy       <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_CHECK) ||
                      (w_state_nxt == S_SLIP)   || (w_state_nxt == S_NEXT);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  assign bitslip     = r_bitslip;
  assign busy        = r_busy;
  assign done        = r_done;
  assign lane_locked = r_locked;
  assign lane_fail   = r_fail;

endmodule

// File: tb/tb_bitslip_align_ctrl.sv
// Bench for bitslip_align_ctrl: deserialiser model per lane, table rows, random runs, corner sequences.
// Main instance uses default parameters; a second small instance covers MAX_SLIPS=0 and SETTLE=1.
// Expected timing comes from a per-lane cycle formula, not from the controller's state machine.
module tb_bitslip_align_ctrl;

  localparam int         LANES     = 4;
  localparam int         SETTLE    = 16;
  localparam int         LOCK_CNT  = 8;
  localparam int         MAX_SLIPS = 20;
  localparam logic [9:0] PAT       = 10'h01F;
  localparam int         NEVER     = 255;

  logic        clk = 1'b0;
  logic        resetn, start, start_z;
  logic [39:0] data;
  logic [3:0]  bitslip, lane_locked, lane_fail;
  logic        busy, done;
  logic [19:0] data_z;
  logic [1:0]  bitslip_z, locked_z, fail_z;
  logic        busy_z, done_z;

  always #5 clk = ~clk;

  bitslip_align_ctrl #(.LANES(LANES), .PATTERN(PAT), .SETTLE(SETTLE),
                       .LOCK_CNT(LOCK_CNT), .MAX_SLIPS(MAX_SLIPS)) dut (
    .clk(clk), .resetn(resetn), .start(start), .data(data), .bitslip(bitslip),
    .busy(busy), .done(done), .lane_locked(lane_locked), .lane_fail(lane_fail));

  bitslip_align_ctrl #(.LANES(2), .PATTERN(PAT), .SETTLE(1),
                       .LOCK_CNT(1), .MAX_SLIPS(0)) dut_z (
    .clk(clk), .resetn(resetn), .start(start_z), .data(data_z), .bitslip(bitslip_z),
    .busy(busy_z), .done(done_z), .lane_locked(locked_z), .lane_fail(fail_z));

  int         checks = 0;
  int         errors = 0;
  int         need[4];
  int         base[4];
  int         slips[4];
  logic [9:0] bad[4];
  logic       glitch = 1'b0;
  int         cyc = 0;
  int         viol = 0;
  int         last_pulse[4] = '{-1000, -1000, -1000, -1000};

  typedef struct packed {
    logic [7:0]  n3, n2, n1, n0;
    logic [3:0]  lock;
    logic [3:0]  fail;
    logic [15:0] cyc;
  } vec_t;
  vec_t tbl[5];

  // Deserialiser model: a lane shows the training word once it has received `need` slips.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (glitch && i == 0)                                data[i*10 +: 10] = 10'h3E0;
      else if (need[i] != NEVER && slips[i] - base[i] >= need[i]) data[i*10 +: 10] = PAT;
      else                                                 data[i*10 +: 10] = bad[i];
    end
  end
  assign data_z = {10'h000, PAT};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (bitslip[i]) slips[i] <= slips[i] + 1;
  end

  // Invariant monitor: one-hot slips only while busy, pulse spacing, exclusive flags.
  always @(negedge clk) begin
    automatic int v = 0;
    cyc <= cyc + 1;
    if ($countones(bitslip) > 1) v++;
    if (bitslip != 4'b0 && !busy) v++;
    if (busy && done) v++;
    if ((lane_locked & lane_fail) != 4'b0) v++;
    if (busy_z && done_z) v++;
    if ((locked_z & fail_z) != 2'b0) v++;
    if (bitslip_z != 2'b0) v++;
    for (int i = 0; i < 4; i++) begin
      if (bitslip[i]) begin
        if (cyc - last_pulse[i] < SETTLE + 1) v++;
        last_pulse[i] <= cyc;
      end
    end
    viol <= viol + v;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane_time(input int k);
    if (k <= MAX_SLIPS) return (k + 1) * SETTLE + 2 * k + LOCK_CNT + 1;
    return (MAX_SLIPS + 1) * (SETTLE + 1) + MAX_SLIPS + 1;
  endfunction

  function automatic logic [9:0] pick_bad();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    while (w == PAT) w = 10'($urandom_range(0, 1023));
    return w;
  endfunction

  task automatic arm(input int nd[4]);
    for (int i = 0; i < 4; i++) begin
      need[i] = nd[i];
      base[i] = slips[i];
      bad[i]  = pick_bad();
    end
  endtask

  task automatic run_case(input string tag, input int nd[4], input logic [3:0] exp_lock,
                          input logic [3:0] exp_fail, input int exp_cyc);
    int bcnt, k, v0, exp_p;
    arm(nd);
    v0 = viol;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, " accept"}, int'({busy, done, lane_locked, lane_fail}), int'({1'b1, 1'b0, 8'h00}));
    bcnt = 1;
    k = 0;
    while (!done && k < 4000) begin
      @(negedge clk);
      k++;
      if (busy) bcnt++;
    end
    check({tag, " done"}, int'(done), 1);
    check({tag, " busy_cycles"}, bcnt, exp_cyc);
    check({tag, " locked"}, int'(lane_locked), int'(exp_lock));
    check({tag, " fail"}, int'(lane_fail), int'(exp_fail));
    for (int i = 0; i < 4; i++) begin
      exp_p = (nd[i] > MAX_SLIPS) ? MAX_SLIPS : nd[i];
      check($sformatf("%s pulses_lane%0d", tag, i), slips[i] - base[i], exp_p);
    end
    check({tag, " invariants"}, viol - v0, 0);
  endtask

  initial begin
    int nd[4];
    int k, bcnt, ec;
    logic [3:0] el, ef;

    tbl[0] = {8'd0, 8'd0, 8'd0,  8'd0,  4'hF, 4'h0, 16'd100};
    tbl[1] = {8'd0, 8'd3, 8'd0,  8'd0,  4'hF, 4'h0, 16'd154};
    tbl[2] = {8'd0, 8'd0, 8'd255, 8'd0, 4'hD, 4'h2, 16'd453};
    tbl[3] = {8'd0, 8'd0, 8'd0,  8'd20, 4'hF, 4'h0, 16'd460};
    tbl[4] = {8'd21, 8'd0, 8'd0, 8'd0,  4'h7, 4'h8, 16'd453};

    for (int i = 0; i < 4; i++) begin
      need[i] = 0; base[i] = 0; slips[i] = 0; bad[i] = 10'h155;
    end
    start = 1'b0; start_z = 1'b0; resetn = 1'b1;
    #2 resetn = 1'b0;
    #1 check("reset outputs", int'({bitslip, busy, done, lane_locked, lane_fail}), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("idle after reset", int'({busy, done, bitslip}), 0);

    // Small instance: SETTLE=1, LOCK_CNT=1, MAX_SLIPS=0 -> lane1 fails on first miss, no pulse.
    @(negedge clk) start_z = 1'b1;
    @(negedge clk) start_z = 1'b0;
    bcnt = 1; k = 0;
    while (!done_z && k < 100) begin
      @(negedge clk); k++;
      if (busy_z) bcnt++;
    end
    check("z done", int'(done_z), 1);
    check("z busy_cycles", bcnt, 6);
    check("z locked", int'(locked_z), 1);
    check("z fail", int'(fail_z), 2);

    for (int r = 0; r < 5; r++) begin
      nd = '{int'(tbl[r].n0), int'(tbl[r].n1), int'(tbl[r].n2), int'(tbl[r].n3)};
      run_case($sformatf("row%0d", r), nd, tbl[r].lock, tbl[r].fail, int'(tbl[r].cyc));
    end

    // Lane 0: five matches, one glitch, then steady; lock must need 8 fresh matches.
    nd = '{0, 0, 0, 0};
    arm(nd);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (21) @(negedge clk);
    glitch = 1'b1;
    @(negedge clk) glitch = 1'b0;
    check("glitch slip pulse", int'(bitslip), 1);
    repeat (24) @(negedge clk);
    check("glitch lock not early", int'(lane_locked[0]), 0);
    @(negedge clk);
    check("glitch lock time", int'(lane_locked[0]), 1);
    k = 0;
    while (!done && k < 1000) begin @(negedge clk); k++; end
    check("glitch done", int'({done, lane_locked}), int'(5'h1F));
    check("glitch pulses", slips[0] - base[0], 1);

    for (int r = 0; r < 6; r++) begin
      el = '0; ef = '0; ec = 0;
      for (int i = 0; i < 4; i++) begin
        nd[i] = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, MAX_SLIPS + 2));
        if (nd[i] <= MAX_SLIPS) el[i] = 1'b1; else ef[i] = 1'b1;
        ec += lane_time(nd[i]);
      end
      run_case($sformatf("rand%0d", r), nd, el, ef, ec);
    end

    // start while busy is ignored; reset during SLIP clears everything at once.
    nd = '{2, 0, 0, 0};
    arm(nd);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 0;
    repeat (4) begin @(negedge clk); k++; end
    start = 1'b1;
    @(negedge clk); k++;
    start = 1'b0;
    while (!bitslip[0] && k < 100) begin @(negedge clk); k++; end
    check("first slip cycle", k, 17);
    resetn = 1'b0;
    #1 check("reset mid slip", int'({bitslip, busy, done, lane_locked, lane_fail}), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    bcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy || done || bitslip != 4'b0) bcnt++;
    end
    check("idle hold after reset", bcnt, 0);

    nd = '{0, 0, 0, 0};
    run_case("post_reset", nd, 4'hF, 4'h0, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitslip_align_ctrl.md
BITSLIP_ALIGN_CTRL -- requirements
Module: bitslip_align_ctrl

Interface
REQ-001 The block SHALL have parameter LANES, default 4: number of 10-bit deserialiser lanes sequenced.
REQ-002 The block SHALL have parameter PATTERN, default 10'h01F: training word expected on every aligned lane.
REQ-003 The block SHALL have parameter SETTLE, default 16: wait cycles after a slip or lane change before comparing (range 1..255).
REQ-004 The block SHALL have parameter LOCK_CNT, default 8: consecutive matching compares required to declare a lane locked (range 1..255).
REQ-005 The block SHALL have parameter MAX_SLIPS, default 20: slips allowed per lane before the lane is declared failed (range 0..255).
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port start, input, 1 bit: request to run or re-run alignment of all lanes.
REQ-009 The block SHALL have port data, input, LANES*10 bits: lane i occupies bits [10i+9:10i].
REQ-010 The block SHALL have port bitslip, output, LANES bits: one-cycle slip pulse to the deserialiser of lane i.
REQ-011 The block SHALL have port busy, output, 1 bit: alignment in progress.
REQ-012 The block SHALL have port done, output, 1 bit: high from sequence completion until the next accepted start.
REQ-013 The block SHALL have port lane_locked, output, LANES bits: lane i aligned to PATTERN.
REQ-014 The block SHALL have port lane_fail, output, LANES bits: lane i exhausted MAX_SLIPS without locking.

Function
REQ-015 The block SHALL implement the states IDLE, SETTLE, CHECK, SLIP, NEXT and DONE.
REQ-016 The block SHALL accept start only in IDLE or DONE; on acceptance it SHALL set lane=0, clear slip_cnt, match_cnt, lane_locked, lane_fail and done, and go to SETTLE.
REQ-017 The block SHALL ignore start while busy is high.
REQ-018 In SETTLE the block SHALL remain exactly SETTLE cycles, then enter CHECK.
REQ-019 The block SHALL compare only data[10*lane+9 : 10*lane] against PATTERN, and only once per cycle in CHECK.
REQ-020 On a CHECK match the block SHALL increment match_cnt; when the increment reaches LOCK_CNT it SHALL set lane_locked[lane] and go to NEXT, otherwise stay in CHECK.
REQ-021 On a CHECK mismatch the block SHALL clear match_cnt, then go to NEXT with lane_fail[lane]=1 if slip_cnt==MAX_SLIPS, otherwise go to SLIP.
REQ-022 SLIP SHALL last one cycle: bitslip[lane]=1 for exactly that cycle, slip_cnt increments, next state SETTLE.
REQ-023 At most one bitslip bit SHALL be high in any cycle, and never outside SLIP.
REQ-024 NEXT SHALL last one cycle: if lane==LANES-1 go to DONE, else increment lane, clear slip_cnt and match_cnt, and go to SETTLE.
REQ-025 In DONE the block SHALL hold done=1, busy=0 and lane_locked/lane_fail unchanged.
REQ-026 busy SHALL be 1 in SETTLE, CHECK, SLIP and NEXT, and 0 in IDLE and DONE; busy and done SHALL never both be 1.
REQ-027 busy SHALL rise in the cycle after start is accepted; done SHALL rise in the cycle after NEXT for the last lane.
REQ-028 Counters SHALL saturate and never wrap; with MAX_SLIPS=0 the first mismatch SHALL fail the lane with no bitslip pulse.
REQ-029 For any lane, lane_locked and lane_fail SHALL never both be 1.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 resetn low SHALL asynchronously force state=IDLE, bitslip=0, busy=0, done=0, lane_locked=0, lane_fail=0, and all counters and lane index to 0, including mid-sequence (e.g. during SLIP, the pulse is cut immediately).
REQ-032 After resetn deasserts, the block SHALL remain in IDLE until start is sampled high.

Verification
REQ-033 LANES=4 defaults, all lanes present 10'h01F from start -> no bitslip pulses; each lane locks after 16 settle + 8 check cycles; done rises; lane_locked=4'b1111.
REQ-034 Lane 2 model needs 3 slips to show 10'h01F -> exactly 3 bitslip[2] pulses, each separated by >=17 cycles; lane_locked=4'b1111, lane_fail=0.
REQ-035 Lane 1 never matches, MAX_SLIPS=20 -> exactly 20 bitslip[1] pulses, then lane_fail=4'b0010; lanes 2-3 are still processed; done=1.
REQ-036 Lane 0 matches 5 times, glitches once, then matches steadily -> match_cnt restarts after the glitch, one slip is issued, lock requires 8 fresh matches.
REQ-037 start pulsed while busy, then resetn pulsed low during a SLIP cycle -> start is ignored; on reset all outputs are 0 immediately and the block sits in IDLE until the next start.
REQ-038 start asserted in DONE -> lane_locked, lane_fail and done clear, busy rises the next cycle, and a full re-alignment runs.
